// File: rtl/eq_sample_queue_if.sv
// eq_sample_queue_if: codec-side sample strobe and replay outputs of the sample queue.
// Carries the overrun flag only when EQ_QUEUE_OVERRUN_EN is defined.
interface eq_sample_queue_if;
  logic wrt_smpl;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rght_smpl;
  logic sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
`ifdef EQ_QUEUE_OVERRUN_EN
  logic overrun;
`endif
  modport master (
    output wrt_smpl, lft_smpl, rght_smpl,
    input sequencing, lft_out, rght_out
`ifdef EQ_QUEUE_OVERRUN_EN
    , input overrun
`endif
  );
  modport slave (
    input wrt_smpl, lft_smpl, rght_smpl,
    output sequencing, lft_out, rght_out
`ifdef EQ_QUEUE_OVERRUN_EN
    , output overrun
`endif
  );
endinterface

// File: rtl/eq_sample_queue.sv
// eq_sample_queue: circular stereo sample store that replays the newest TAPS samples per new sample.
// Optional sticky overrun flag with EQ_QUEUE_OVERRUN_EN.
module eq_sample_queue #(
  parameter int DEPTH = 1536,
  parameter int TAPS = 1021
) (
  input logic clk,
  input logic rst_n,
  eq_sample_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  typedef enum logic [1:0] {FILL, IDLE, SWEEP, GAP} state_t;
  state_t state, state_nxt;
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data;
  logic [AW-1:0] new_ptr, old_ptr, rd_ptr, old_nxt;
  logic [CW-1:0] cnt, k;
  logic pending, pending_nxt, valid_q, full, last, start;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full = cnt == CW'(TAPS);
  assign last = (state == SWEEP) && (k == CW'(TAPS - 1));
  assign old_nxt = (q.wrt_smpl && full) ? inc(old_ptr) : old_ptr;
  always_comb begin
    state_nxt = state;
    pending_nxt = pending;
    start = 1'b0;
    case (state)
      FILL: if (q.wrt_smpl && cnt == CW'(TAPS - 1)) begin
        state_nxt = SWEEP;
        start = 1'b1;
      end
      IDLE: if (q.wrt_smpl) begin
        state_nxt = SWEEP;
        start = 1'b1;
      end
      SWEEP: if (last) begin
        state_nxt = (pending || q.wrt_smpl) ? GAP : IDLE;
        pending_nxt = 1'b0;
      end else if (q.wrt_smpl) pending_nxt = 1'b1;
      default: begin
        state_nxt = SWEEP;
        start = 1'b1;
      end
    endcase
  end
  // GAP is the one-cycle sequencing dip between back-to-back sweeps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      pending <= 1'b0;
      cnt <= '0;
      k <= '0;
      new_ptr <= '0;
      old_ptr <= '0;
      rd_ptr <= '0;
      valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pending <= pending_nxt;
      cnt <= (q.wrt_smpl && !full) ? cnt + 1'b1 : cnt;
      new_ptr <= q.wrt_smpl ? inc(new_ptr) : new_ptr;
      old_ptr <= old_nxt;
      rd_ptr <= start ? old_nxt : (state == SWEEP) ? inc(rd_ptr) : rd_ptr;
      k <= start ? '0 : (state == SWEEP) ? k + 1'b1 : k;
      valid_q <= state == SWEEP;
    end
  end
  always_ff @(posedge clk) begin
    if (q.wrt_smpl) mem[new_ptr] <= {q.lft_smpl, q.rght_smpl};
    if (state == SWEEP) rd_data <= mem[rd_ptr];
  end
`ifdef EQ_QUEUE_OVERRUN_EN
  logic overrun;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else if (q.wrt_smpl && pending) overrun <= 1'b1;
  end
  assign q.overrun = overrun;
`endif
  assign q.sequencing = state == SWEEP;
  assign q.lft_out = valid_q ? rd_data[31:16] : '0;
  assign q.rght_out = valid_q ? rd_data[15:0] : '0;
endmodule
